decode_stage_pipe: RTL

- Parametrised next-generation decode stage.
- Contains a DATA_W x 2^REG_AW register file with two read ports and one write port, plus write-through bypass and the IN-port operand mux on source 1.
- Adds load-use hazard detection and an ID/EX pipeline register with valid, stall, flush and bubble insertion.
- Sits between fetch/IF-ID and execute; the control word is produced externally and carried through.

---
 rtl/decode_stage_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode stage with register file, write-through bypass,
// IN-port operand mux, load-use hazard detection and an ID/EX pipeline register.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   id_valid             decode slot holds a valid instruction
//   rs1, rs2, rd         source / destination register addresses
//   uses_rs1, uses_rs2   instruction actually reads rs1 / rs2
//   ctrl_in              externally decoded control word, carried to EX
//   in_port              external input, replaces operand 1 when selected
//   wb_en/addr/data      register file write port (from writeback)
//   ex_stall             execute cannot accept; ID/EX holds
//   flush                kill the decode instruction, clear ID/EX valid
//   id_ready             decode instruction consumed this cycle
//   load_use_stall       load-use hazard forces a bubble this cycle
//   ex_*                 ID/EX pipeline register contents

module decode_stage_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned CTRL_W     = 41,
    parameter int unsigned IN_SEL_BIT = 18,
    parameter int unsigned MEMRD_BIT  = 0,
    parameter bit          R0_ZERO    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] in_port,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_ready,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    logic [DATA_W-1:0] rf_q [NumRegs];
    logic              wr_ok;
    logic [DATA_W-1:0] rdata1, rdata2, op1;
    logic              hz;

    // Writes to r0 are dropped when r0 is hardwired to zero.
    assign wr_ok = wb_en && !(R0_ZERO && (wb_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Bypass first: a same-cycle write is visible to the reader.
    always_comb begin
        rdata1 = rf_q[rs1];
        rdata2 = rf_q[rs2];
        if (R0_ZERO && (rs1 == '0)) rdata1 = '0;
        if (R0_ZERO && (rs2 == '0)) rdata2 = '0;
        if (wr_ok && (wb_addr == rs1)) rdata1 = wb_data;
        if (wr_ok && (wb_addr == rs2)) rdata2 = wb_data;
    end

    assign op1 = ctrl_in[IN_SEL_BIT] ? in_port : rdata1;

    assign hz = id_valid && ex_valid && ex_ctrl[MEMRD_BIT] &&
                ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

    assign load_use_stall = hz && !flush && !ex_stall;

    // A flushed instruction counts as consumed; stalls and bubbles hold it in decode.
    always_comb begin
        if (flush)               id_ready = 1'b1;
        else if (ex_stall)       id_ready = 1'b0;
        else if (load_use_stall) id_ready = 1'b0;
        else                     id_ready = id_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
        end else if (flush || (!ex_stall && load_use_stall)) begin
            // Flush and bubble both leave an empty slot; data fields keep their value.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!ex_stall) begin
            ex_valid <= id_valid;
            ex_ctrl  <= ctrl_in;
            ex_op1   <= op1;
            ex_op2   <= rdata2;
            ex_rs1   <= rs1;
            ex_rs2   <= rs2;
            ex_rd    <= rd;
        end
    end

endmodule
